// File: rtl/mat_pkg.sv
// Shared definitions for the matrix row cache: request opcodes, controller
// states, lane width and default geometry.
package mat_pkg;

  localparam int MAT_WIDTH_DEF     = 128;  // lanes per row
  localparam int MAT_CACHESIZE_DEF = 256;  // rows
  localparam int MAT_LANE_BITS     = 32;   // one IEEE-754 single per lane

  typedef enum logic [1:0] {
    MAT_OP_NOP   = 2'b00,
    MAT_OP_READ  = 2'b01,
    MAT_OP_WRITE = 2'b10,
    MAT_OP_RDWR  = 2'b11
  } mat_op_e;

  typedef enum logic {
    MAT_ST_IDLE  = 1'b0,
    MAT_ST_CLEAR = 1'b1
  } mat_state_e;

  function automatic logic op_reads(input logic [1:0] op);
    return (op == MAT_OP_READ) || (op == MAT_OP_RDWR);
  endfunction

  function automatic logic op_writes(input logic [1:0] op);
    return (op == MAT_OP_WRITE) || (op == MAT_OP_RDWR);
  endfunction

endpackage

// File: rtl/mat_cache_mem.sv
// Row storage for mat_cache_v2: one registered read port and one lane-masked
// write port. Lanes carry raw IEEE-754 single-precision bit patterns; the
// array itself has no reset and is zeroed by the controller's clear sweep.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//                     (reset only clears the read register)
//   rd_en, rd_addr    read strobe/address; rd_data updates on the next edge
//   rd_data           registered read data, holds while rd_en is low
//   wr_en, wr_addr    write strobe/address
//   wr_mask           per-lane write enable
//   wr_data           write data
// A read and write to the same row on one edge returns the old contents.
module mat_cache_mem
  import mat_pkg::*;
#(
  parameter int WIDTH = MAT_WIDTH_DEF,
  parameter int DEPTH = MAT_CACHESIZE_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                rd_en,
  input  logic [AW-1:0]                       rd_addr,
  output logic [WIDTH-1:0][MAT_LANE_BITS-1:0] rd_data,
  input  logic                                wr_en,
  input  logic [AW-1:0]                       wr_addr,
  input  logic [WIDTH-1:0]                    wr_mask,
  input  logic [WIDTH-1:0][MAT_LANE_BITS-1:0] wr_data
);

  logic [WIDTH-1:0][MAT_LANE_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (wr_mask[i]) mem[wr_addr][i] <= wr_data[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mat_cache_v2.sv
// Matrix row cache: CACHESIZE rows of WIDTH single-precision lanes with a
// valid/ready request port, latency-1 reads, lane-masked writes and a
// one-row-per-cycle clear sweep. Reset starts a sweep, so the array is
// zeroed before any request is accepted.
//
// Optional build macro: MAT_CACHE_BYPASS_EN -- RDWR with addr1==addr2 returns
// the newly written lanes (read-after-write). Without it the same case
// returns the pre-write row (read-before-write).
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   clear_req           one-cycle request to zero the whole array
//   req_valid/req_ready request handshake, ready only in IDLE with no clear
//   op                  00 NOP, 01 READ, 10 WRITE, 11 RDWR
//   addr1 / addr2       read / write row address
//   lane_en, data_in    per-lane write enable and write data (IEEE-754 bits)
//   rsp_valid, data_out read response, one cycle after acceptance;
//                       data_out holds while rsp_valid is low
//   busy                clear sweep in progress
//
// state | meaning
// IDLE  | accepting requests; clear_req starts a sweep
// CLEAR | zeroing row cnt each cycle, requests and clear_req ignored
module mat_cache_v2
  import mat_pkg::*;
#(
  parameter int WIDTH     = MAT_WIDTH_DEF,
  parameter int CACHESIZE = MAT_CACHESIZE_DEF,  // power of two, >= 2
  parameter int CACHEADDR = $clog2(CACHESIZE)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                clear_req,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [1:0]                          op,
  input  logic [CACHEADDR-1:0]                addr1,
  input  logic [CACHEADDR-1:0]                addr2,
  input  logic [WIDTH-1:0]                    lane_en,
  input  logic [WIDTH-1:0][MAT_LANE_BITS-1:0] data_in,
  output logic                                rsp_valid,
  output logic [WIDTH-1:0][MAT_LANE_BITS-1:0] data_out,
  output logic                                busy
);

  localparam logic [CACHEADDR-1:0] LAST_ROW = CACHEADDR'(CACHESIZE - 1);

  mat_state_e                          state, state_next;
  logic [CACHEADDR-1:0]                cnt, cnt_next;
  logic                                accept;
  logic                                rd_en;
  logic                                wr_en;
  logic [CACHEADDR-1:0]                wr_addr;
  logic [WIDTH-1:0]                    wr_mask;
  logic [WIDTH-1:0][MAT_LANE_BITS-1:0] wr_data;
  logic [WIDTH-1:0][MAT_LANE_BITS-1:0] mem_rd;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= MAT_ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = addr2;
    wr_mask    = lane_en;
    wr_data    = data_in;
    case (state)
      MAT_ST_IDLE: begin
        req_ready = !clear_req;
        if (clear_req) begin
          state_next = MAT_ST_CLEAR;
          cnt_next   = '0;
        end else begin
          accept = req_valid;
          rd_en  = accept && op_reads(op);
          wr_en  = accept && op_writes(op);
        end
      end
      MAT_ST_CLEAR: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = cnt;
        wr_mask = '1;
        wr_data = '0;
        // Hold at the last row rather than wrapping; IDLE ignores cnt.
        if (cnt == LAST_ROW) state_next = MAT_ST_IDLE;
        else cnt_next = cnt + CACHEADDR'(1);
      end
      default: state_next = MAT_ST_CLEAR;
    endcase
    // Reset overrides everything on its edge, including array writes and a
    // read presented in the same cycle.
    if (reset) begin
      accept = 1'b0;
      rd_en  = 1'b0;
      wr_en  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rsp_valid <= 1'b0;
    else rsp_valid <= rd_en;
  end

  mat_cache_mem #(
    .WIDTH(WIDTH),
    .DEPTH(CACHESIZE),
    .AW   (CACHEADDR)
  ) u_mem (
    .clock  (clock),
    .reset  (reset),
    .rd_en  (rd_en),
    .rd_addr(addr1),
    .rd_data(mem_rd),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_mask(wr_mask),
    .wr_data(wr_data)
  );

`ifdef MAT_CACHE_BYPASS_EN
  // The memory returns the old row on a same-row RDWR, so the written lanes
  // are captured alongside the read and merged over the memory output. The
  // capture only reloads on a read, so data_out still holds between reads.
  logic                                byp_hit;
  logic [WIDTH-1:0]                    byp_mask;
  logic [WIDTH-1:0][MAT_LANE_BITS-1:0] byp_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      byp_hit  <= 1'b0;
      byp_mask <= '0;
      byp_data <= '0;
    end else if (rd_en) begin
      byp_hit  <= (op == MAT_OP_RDWR) && (addr1 == addr2);
      byp_mask <= lane_en;
      byp_data <= data_in;
    end
  end

  always_comb begin
    data_out = mem_rd;
    for (int i = 0; i < WIDTH; i++) begin
      if (byp_hit && byp_mask[i]) data_out[i] = byp_data[i];
    end
  end
`else
  assign data_out = mem_rd;
`endif

endmodule

// File: tb/tb_mat_cache_v2.sv
module tb_mat_cache_v2;

  localparam int W = 128;
  localparam int N = 256;
`ifdef MAT_CACHE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic                clear_req;
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          op;
  logic [7:0]          addr1;
  logic [7:0]          addr2;
  logic [W-1:0]        lane_en;
  logic [W-1:0][31:0]  data_in;
  logic                rsp_valid;
  logic [W-1:0][31:0]  data_out;
  logic                busy;

  int total = 0;
  int bad   = 0;
  logic [W-1:0][31:0] model [N];
  logic [W-1:0][31:0] exp_dout;

  mat_cache_v2 dut (
    .clock    (clock),
    .reset    (reset),
    .clear_req(clear_req),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .op       (op),
    .addr1    (addr1),
    .addr2    (addr2),
    .lane_en  (lane_en),
    .data_in  (data_in),
    .rsp_valid(rsp_valid),
    .data_out (data_out),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // IEEE-754 single bit pattern of a small non-negative integer.
  function automatic logic [31:0] int_to_f(input int n);
    int e;
    if (n == 0) return 32'h0;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((n << (23 - e)) & 32'h7f_ffff)};
  endfunction

  function automatic int first_diff(input logic [W-1:0][31:0] a, input logic [W-1:0][31:0] b);
    for (int l = 0; l < W; l++) if (a[l] !== b[l]) return l;
    return 0;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    clear_req = 1'b0;
    req_valid = 1'b0;
    op        = 2'b00;
    lane_en   = '0;
  endtask

  task automatic zero_model();
    for (int r = 0; r < N; r++) model[r] = '0;
  endtask

  task automatic wait_sweep(output int n, output int ready_hi);
    n = 0;
    ready_hi = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (req_ready !== 1'b0) ready_hi++;
      step();
      n++;
    end
  endtask

  task automatic do_write(input int a, input logic [W-1:0] m, input logic [W-1:0][31:0] d);
    req_valid = 1'b1; op = 2'b10; addr2 = 8'(a); lane_en = m; data_in = d;
    step();
    drive_idle();
    for (int l = 0; l < W; l++) if (m[l]) model[a][l] = d[l];
  endtask

  task automatic do_read_check(input string name, input int a);
    int l;
    req_valid = 1'b1; op = 2'b01; addr1 = 8'(a);
    step();
    drive_idle();
    exp_dout = model[a];
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++; $display("FAIL %s rsp_valid got %b want 1", name, rsp_valid);
    end
    total++;
    if (data_out !== exp_dout) begin
      bad++; l = first_diff(data_out, exp_dout);
      $display("FAIL %s data lane %0d got %h want %h", name, l, data_out[l], exp_dout[l]);
    end
  endtask

  task automatic test_reset();
    int n, rh;
    drive_idle();
    reset = 1'b1;
    step();
    step();
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL reset_outputs rsp_valid/busy got %b/%b want 0/1", rsp_valid, busy);
    end
    total++;
    if (data_out !== '0) begin
      bad++; $display("FAIL reset_data lane0 got %h want 0", data_out[0]);
    end
    reset = 1'b0;
    exp_dout = '0;
    zero_model();
    wait_sweep(n, rh);
    total++;
    if (n != N) begin
      bad++; $display("FAIL reset_sweep_len got %0d want %0d", n, N);
    end
    total++;
    if (rh != 0) begin
      bad++; $display("FAIL reset_sweep_ready got %0d ready cycles want 0", rh);
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_sweep got %b want 1", req_ready);
    end
    do_read_check("read_row255_zero", 255);
  endtask

  task automatic test_write_read();
    logic [W-1:0][31:0] d;
    for (int l = 0; l < W; l++) d[l] = int_to_f(l);
    do_write(5, '1, d);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL write_no_rsp got %b want 0", rsp_valid);
    end
    do_read_check("write_read_row5", 5);
    total++;
    if (data_out[7] !== 32'h40E0_0000) begin
      bad++; $display("FAIL write_read_lane7 got %h want 40e00000", data_out[7]);
    end
    step();
    total++;
    if (rsp_valid !== 1'b0 || data_out !== exp_dout) begin
      bad++; $display("FAIL hold_after_read rsp_valid got %b want 0 lane7 got %h want %h",
                      rsp_valid, data_out[7], exp_dout[7]);
    end
  endtask

  task automatic test_masked_write();
    logic [W-1:0][31:0] d;
    for (int l = 0; l < W; l++) d[l] = 32'h4118_0000;
    do_write(5, W'(1), d);
    do_read_check("masked_row5", 5);
    total++;
    if (data_out[0] !== 32'h4118_0000 || data_out[1] !== 32'h3F80_0000) begin
      bad++; $display("FAIL masked_lanes got %h/%h want 41180000/3f800000", data_out[0], data_out[1]);
    end
  endtask

  task automatic test_rdwr_same();
    logic [W-1:0][31:0] d2, d4;
    logic [31:0] want;
    for (int l = 0; l < W; l++) begin
      d2[l] = 32'h4000_0000;
      d4[l] = 32'h4080_0000;
    end
    do_write(3, '1, d2);
    req_valid = 1'b1; op = 2'b11; addr1 = 8'd3; addr2 = 8'd3; lane_en = '1; data_in = d4;
    step();
    drive_idle();
    model[3] = d4;
    want = BYP ? 32'h4080_0000 : 32'h4000_0000;
    exp_dout = BYP ? d4 : d2;
    total++;
    if (rsp_valid !== 1'b1 || data_out[0] !== want || data_out !== exp_dout) begin
      bad++; $display("FAIL rdwr_same rsp_valid %b lane0 got %h want %h", rsp_valid, data_out[0], want);
    end
    do_read_check("rdwr_after", 3);
  endtask

  task automatic test_random();
    int l;
    logic exp_rv;
    logic [W-1:0][31:0] rd;
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      op = 2'($urandom_range(0, 3));
      addr1 = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      addr2 = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) addr2 = addr1;
      lane_en = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < W; k++) data_in[k] = $urandom;
      #1;
      total++;
      if (req_ready !== 1'b1) begin
        bad++; $display("FAIL rand_ready cycle %0d got %b want 1", c, req_ready);
      end
      exp_rv = req_valid && (op == 2'b01 || op == 2'b11);
      if (exp_rv) begin
        rd = model[addr1];
        if (BYP && op == 2'b11 && addr1 == addr2)
          for (int k = 0; k < W; k++) if (lane_en[k]) rd[k] = data_in[k];
        exp_dout = rd;
      end
      if (req_valid && (op == 2'b10 || op == 2'b11))
        for (int k = 0; k < W; k++) if (lane_en[k]) model[addr2][k] = data_in[k];
      step();
      total++;
      if (rsp_valid !== exp_rv) begin
        bad++; $display("FAIL rand_rsp_valid cycle %0d got %b want %b", c, rsp_valid, exp_rv);
      end
      total++;
      if (data_out !== exp_dout) begin
        bad++; l = first_diff(data_out, exp_dout);
        $display("FAIL rand_data cycle %0d lane %0d got %h want %h", c, l, data_out[l], exp_dout[l]);
      end
    end
    drive_idle();
  endtask

  task automatic test_clear_collision();
    int n, rh;
    logic [W-1:0][31:0] d;
    for (int l = 0; l < W; l++) d[l] = 32'h4120_0000;
    clear_req = 1'b1; req_valid = 1'b1; op = 2'b10; addr2 = 8'd10; lane_en = '1; data_in = d;
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL collision_ready got %b want 0", req_ready);
    end
    step();
    drive_idle();
    total++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL collision_busy busy got %b want 1 rsp_valid got %b want 0", busy, rsp_valid);
    end
    step();
    clear_req = 1'b1;  // must be ignored mid-sweep
    step();
    clear_req = 1'b0;
    wait_sweep(n, rh);
    total++;
    if (n != N - 2) begin
      bad++; $display("FAIL collision_sweep_len got %0d want %0d", n, N - 2);
    end
    zero_model();
    do_read_check("collision_row10", 10);
    do_read_check("cleared_row5", 5);
  endtask

  task automatic test_reset_mid_sweep();
    int n, rh;
    logic [W-1:0][31:0] d;
    for (int l = 0; l < W; l++) d[l] = $urandom | 32'h1;
    do_write(20, '1, d);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (100) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_dout = '0;
    wait_sweep(n, rh);
    total++;
    if (n != N) begin
      bad++; $display("FAIL restart_sweep_len got %0d want %0d", n, N);
    end
    zero_model();
    do_read_check("restart_row20", 20);
  endtask

  task automatic test_reset_mid_read();
    int n, rh;
    logic [W-1:0][31:0] d;
    for (int l = 0; l < W; l++) d[l] = $urandom | 32'h1;
    do_write(30, '1, d);
    do_read_check("preread_row30", 30);
    req_valid = 1'b1; op = 2'b01; addr1 = 8'd30; reset = 1'b1;
    step();
    drive_idle();
    reset = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_read_rsp got %b want 0", rsp_valid);
    end
    total++;
    if (data_out !== '0 || busy !== 1'b1) begin
      bad++; $display("FAIL reset_read_state lane0 got %h want 0 busy got %b want 1", data_out[0], busy);
    end
    wait_sweep(n, rh);
    total++;
    if (n != N) begin
      bad++; $display("FAIL reset_read_sweep got %0d want %0d", n, N);
    end
    zero_model();
    do_read_check("reset_read_row30", 30);
  endtask

  initial begin
    reset = 1'b1;
    addr1 = '0;
    addr2 = '0;
    data_in = '0;
    drive_idle();
    test_reset();
    test_write_read();
    test_masked_write();
    test_rdwr_same();
    test_random();
    test_clear_collision();
    test_reset_mid_sweep();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mat_cache_v2.md
MAT_CACHE_V2 -- requirements
Module: mat_cache_v2

Interface
REQ-001 SHALL have parameter WIDTH, default 128: lanes per row, each lane one shortreal (IEEE-754 single).
REQ-002 SHALL have parameter CACHESIZE, default 256: number of rows; SHALL be a power of two, at least 2.
REQ-003 SHALL have parameter CACHEADDR, default $clog2(CACHESIZE): address width.
REQ-004 SHALL have a single clock and a synchronous, active-high reset.
REQ-005 SHALL have these ports, clock and reset first:
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous active-high reset.
- clear_req  input  1  one-cycle request to zero the whole array.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when high with req_valid.
- op  input  2  00 NOP, 01 READ, 10 WRITE, 11 RDWR.
- addr1  input  CACHEADDR  read address.
- addr2  input  CACHEADDR  write address.
- lane_en  input  WIDTH  per-lane write enable.
- data_in  input  shortreal[WIDTH]  write data.
- rsp_valid  output  1  data_out valid.
- data_out  output  shortreal[WIDTH]  read data.
- busy  output  1  clear sweep in progress.

Function
REQ-006 SHALL implement FSM states IDLE and CLEAR.
REQ-007 req_ready SHALL equal (state==IDLE && !clear_req), combinationally.
REQ-008 A request is accepted on a cycle with req_valid && req_ready. No other cycle SHALL modify the array, except a CLEAR sweep.
REQ-009 An accepted WRITE or RDWR SHALL update every lane i with lane_en[i]=1 at row addr2 on that edge. Lanes with lane_en[i]=0 SHALL keep their value.
REQ-010 An accepted READ or RDWR SHALL drive row addr1 on data_out with rsp_valid=1 exactly one cycle later (latency 1).
REQ-011 rsp_valid SHALL be 0 in every cycle not following an accepted READ/RDWR. data_out SHALL hold its last value while rsp_valid=0.
REQ-012 NOP, and any cycle without acceptance, SHALL have no effect.
REQ-013 In IDLE, clear_req=1 SHALL transition to CLEAR and reset the sweep counter to 0. Any concurrent req_valid SHALL NOT be accepted: clear wins.
REQ-014 In CLEAR:
- one row (counter value) SHALL be written to 0.0 in all lanes per cycle;
- the counter SHALL increment;
- after row CACHESIZE-1 the FSM SHALL return to IDLE.
The sweep takes exactly CACHESIZE cycles.
REQ-015 busy SHALL be 1 exactly while state==CLEAR. clear_req SHALL be ignored while in CLEAR.
REQ-016 The counter SHALL be CACHEADDR bits wide. Terminal detection SHALL use counter==CACHESIZE-1, with no wrap past it.
REQ-017 Addresses SHALL be used as-is, with no bounds check needed: width equals depth.

Reset
REQ-018 reset=1 SHALL force the following on the next edge, overriding all other inputs:
- state=CLEAR, counter=0;
- rsp_valid=0, data_out all lanes 0.0.
Memory is therefore zeroed by the post-reset sweep.
REQ-019 reset asserted during a CLEAR sweep SHALL restart the sweep from row 0.
REQ-020 reset asserted with a pending read SHALL suppress its response.

Configuration
REQ-021 Macro MAT_CACHE_BYPASS_EN, when defined, SHALL enable read-after-write forwarding. For an accepted RDWR with addr1==addr2, lanes with lane_en=1 return data_in and other lanes return stored data.
REQ-022 Without MAT_CACHE_BYPASS_EN, that case SHALL return the pre-write row contents (read-before-write).

Structure
REQ-023 Package mat_pkg SHALL hold:
- the op enum (MAT_OP_NOP/READ/WRITE/RDWR);
- the FSM state enum;
- the default WIDTH/CACHESIZE constants.
REQ-024 The storage array SHALL be a sub-module mat_cache_mem: one read port, one masked write port, registered read.
REQ-025 The FSM, counter, handshake and bypass mux SHALL reside in mat_cache_v2.

Verification
REQ-026 Reset, then hold reset=0 -> busy=1 for exactly 256 cycles and req_ready=0 throughout; a READ of row 255 afterwards returns all lanes 0.0.
REQ-027 WRITE addr2=5 with data lane i=i*1.0 and lane_en all-1, then READ addr1=5 -> next cycle rsp_valid=1 and lane 7=7.0.
REQ-028 WRITE addr2=5 with lane_en=only lane 0 and data 9.5, then READ 5 -> lane 0=9.5 and lane 1 keeps 1.0.
REQ-029 RDWR addr1=addr2=3 with prior row 2.0 and new 4.0 -> data_out 4.0 with MAT_CACHE_BYPASS_EN, 2.0 without.
REQ-030 Assert clear_req and req_valid (WRITE) in the same cycle -> write not accepted and busy=1 next cycle.
REQ-031 Assert reset at sweep cycle 100 -> sweep restarts and busy stays high 256 more cycles; reset mid-read gives rsp_valid=0.
